// File: rtl/demux_rr_scheduler_pkg.sv
// Shared types and helpers for the demux round-robin scheduler.
// Helpers take the channel count as an argument so any instance size can use them.
package demux_sched_pkg;

   localparam int MAX_N = 16;

   typedef enum logic {
      EMPTY  = 1'b0,
      LOADED = 1'b1
   } state_t;

   // Callers truncate the result to their own channel count.
   function automatic logic [MAX_N-1:0] onehot(input int s);
      return MAX_N'(1) << s;
   endfunction

   function automatic int wrap_inc(input int x, input int n);
      return (x == n - 1) ? 0 : x + 1;
   endfunction

endpackage

// File: rtl/demux_rr_scheduler_rr_pick.sv
// Rotate-priority search: first requesting channel at or after start, modulo N.
// With no request pending, grant_idx falls back to start and any stays low.
module rr_pick #(
   parameter int N     = 8,
   parameter int SEL_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] start,
   output logic [SEL_W-1:0] grant_idx,
   output logic             any
);

   int idx;

   // The scan runs from the far end back toward start, so the closest hit wins.
   always_comb begin
      grant_idx = start;
      any       = 1'b0;
      idx       = 0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (32'(start) + i) % N;
         if (req[idx]) begin
            grant_idx = SEL_W'(idx);
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux_rr_scheduler.sv
// One-word holding stage in front of a 1xN demux; picks a destination per word
// either round-robin over ready sinks or from a software-selected fixed channel.
module demux_rr_scheduler
   import demux_sched_pkg::*;
#(
   parameter int N     = 8,
   parameter int SEL_W = 3,
   parameter int DW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [DW-1:0]    in_data,
   output logic             in_ready,
   input  logic             mode,
   input  logic [SEL_W-1:0] fix_sel,
   input  logic [N-1:0]     out_ready,
   output logic [N-1:0]     out_valid,
   output logic [DW-1:0]    out_data,
   output logic [SEL_W-1:0] sel,
   output logic [SEL_W-1:0] rr_ptr
);

   state_t           state;
   logic             delivery;
   logic             sel_legal;
   logic             accept;
   logic [SEL_W-1:0] rr_grant;
   logic             rr_any;
   logic [SEL_W-1:0] dest;

   rr_pick #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_rr_pick (
      .req       (out_ready),
      .start     (rr_ptr),
      .grant_idx (rr_grant),
      .any       (rr_any)
   );

   // Ready is checked through a one-hot mask so a wide sel never indexes past N-1.
   assign delivery  = (state == LOADED) && |(out_ready & N'(onehot(32'(sel))));
   assign sel_legal = !mode || (32'(fix_sel) < N);
   assign in_ready  = !rst && (state == EMPTY || delivery) && sel_legal;
   assign accept    = in_valid && in_ready;
   assign dest      = mode ? fix_sel : (rr_any ? rr_grant : rr_ptr);

   // A new word may replace a delivering one on the same edge, giving one word per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         out_valid <= '0;
         out_data  <= '0;
         sel       <= '0;
         rr_ptr    <= '0;
      end else if (accept) begin
         state     <= LOADED;
         out_valid <= N'(onehot(32'(dest)));
         out_data  <= in_data;
         sel       <= dest;
         if (!mode)
            rr_ptr <= SEL_W'(wrap_inc(32'(dest), N));
      end else if (delivery) begin
         state     <= EMPTY;
         out_valid <= '0;
      end
   end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Drives an 8-channel and a 5-channel scheduler in lockstep and compares both
// against a word-level model of the delivery and arbitration rules.
module tb_demux_rr_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       mode = 1'b0;
   logic [2:0] fix_sel = '0;
   logic [7:0] out_ready = '0;

   logic       in_ready8, in_ready5;
   logic [7:0] out_valid8;
   logic [4:0] out_valid5;
   logic [7:0] out_data8, out_data5;
   logic [2:0] sel8, sel5, rr_ptr8, rr_ptr5;

   int num_checks   = 0;
   int num_failures = 0;

   int nch[2]    = '{8, 5};
   int m_held[2] = '{0, 0};
   int m_sel[2]  = '{0, 0};
   int m_data[2] = '{0, 0};
   int m_ptr[2]  = '{0, 0};

   always #5 clk = ~clk;

   demux_rr_scheduler #(.N(8), .SEL_W(3), .DW(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready8), .mode(mode), .fix_sel(fix_sel),
      .out_ready(out_ready), .out_valid(out_valid8), .out_data(out_data8),
      .sel(sel8), .rr_ptr(rr_ptr8)
   );

   demux_rr_scheduler #(.N(5), .SEL_W(3), .DW(8)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready5), .mode(mode), .fix_sel(fix_sel),
      .out_ready(out_ready[4:0]), .out_valid(out_valid5), .out_data(out_data5),
      .sel(sel5), .rr_ptr(rr_ptr5)
   );

   task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
      num_checks++;
      if (observed !== expected) begin
         num_failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock: drive on the falling edge, check in_ready, advance the model, check registers.
   task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d,
                                input logic md, input logic [2:0] fs, input logic [7:0] rdy);
      int exp_ready[2];
      int obs_ready, c, n;
      int deliv, legal, dest;
      @(negedge clk);
      rst = r; in_valid = v; in_data = d; mode = md; fix_sel = fs; out_ready = rdy;
      #1;
      for (int u = 0; u < 2; u++) begin
         n         = nch[u];
         legal     = (!md || int'(fs) < n) ? 1 : 0;
         deliv     = (m_held[u] != 0 && rdy[m_sel[u]]) ? 1 : 0;
         exp_ready[u] = (!r && (m_held[u] == 0 || deliv != 0) && legal != 0) ? 1 : 0;
         obs_ready = (u == 0) ? int'(in_ready8) : int'(in_ready5);
         checkOutput($sformatf("in_ready_n%0d", n), obs_ready, exp_ready[u]);
         if (r) begin
            m_held[u] = 0; m_sel[u] = 0; m_data[u] = 0; m_ptr[u] = 0;
         end else if (v && exp_ready[u] != 0) begin
            if (md) begin
               dest = int'(fs);
            end else begin
               dest = m_ptr[u];
               for (int k = n - 1; k >= 0; k--) begin
                  c = (m_ptr[u] + k) % n;
                  if (rdy[c]) dest = c;
               end
               m_ptr[u] = (dest + 1) % n;
            end
            m_held[u] = 1; m_sel[u] = dest; m_data[u] = int'(d);
         end else if (deliv != 0) begin
            m_held[u] = 0;
         end
      end
      @(posedge clk);
      #1;
      checkOutput("out_valid_n8", out_valid8, m_held[0] != 0 ? (1 << m_sel[0]) : 0);
      checkOutput("out_data_n8",  out_data8,  m_data[0]);
      checkOutput("sel_n8",       sel8,       m_sel[0]);
      checkOutput("rr_ptr_n8",    rr_ptr8,    m_ptr[0]);
      checkOutput("out_valid_n5", out_valid5, m_held[1] != 0 ? (1 << m_sel[1]) : 0);
      checkOutput("out_data_n5",  out_data5,  m_data[1]);
      checkOutput("sel_n5",       sel5,       m_sel[1]);
      checkOutput("rr_ptr_n5",    rr_ptr5,    m_ptr[1]);
   endtask

   initial begin
      applyStimulus(1, 0, 8'h00, 0, 3'd0, 8'hFF);
      applyStimulus(1, 0, 8'h00, 0, 3'd0, 8'hFF);

      // Round-robin streaming with every sink ready; both sizes wrap at their own N.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 1, 8'hA0 + 8'(i), 0, 3'd0, 8'hFF);
         checkOutput("stream_sel_n8", sel8, i % 8);
         checkOutput("stream_sel_n5", sel5, i % 5);
      end
      applyStimulus(0, 0, 8'h00, 0, 3'd0, 8'hFF);

      // Bring rr_ptr to 2, then skip not-ready channels.
      applyStimulus(1, 0, 8'h00, 0, 3'd0, 8'hFF);
      applyStimulus(0, 1, 8'h10, 0, 3'd0, 8'hFF);
      applyStimulus(0, 1, 8'h11, 0, 3'd0, 8'hFF);
      applyStimulus(0, 0, 8'h00, 0, 3'd0, 8'hFF);
      checkOutput("skip_ptr_start", rr_ptr8, 2);
      applyStimulus(0, 1, 8'h12, 0, 3'd0, 8'b0010_0001);
      checkOutput("skip_sel_5", sel8, 5);
      checkOutput("skip_ptr_6", rr_ptr8, 6);
      applyStimulus(0, 1, 8'h13, 0, 3'd0, 8'b0010_0001);
      checkOutput("skip_sel_0", sel8, 0);
      checkOutput("skip_ptr_1", rr_ptr8, 1);
      applyStimulus(0, 0, 8'h00, 0, 3'd0, 8'hFF);

      // Fixed channel 3 stalled for four cycles, then released with a word waiting.
      applyStimulus(0, 1, 8'h33, 1, 3'd3, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 8'h34, 1, 3'd3, 8'hF7);
         checkOutput("stall_valid", out_valid8, 8'h08);
         checkOutput("stall_data", out_data8, 8'h33);
      end
      applyStimulus(0, 1, 8'h34, 1, 3'd3, 8'hFF);
      checkOutput("release_data", out_data8, 8'h34);
      applyStimulus(0, 0, 8'h00, 1, 3'd3, 8'hFF);

      // Channels 5..7 are illegal for the 5-channel instance only.
      applyStimulus(0, 1, 8'h66, 1, 3'd6, 8'hFF);
      checkOutput("illegal_valid_n5", out_valid5, 0);
      applyStimulus(0, 1, 8'h67, 0, 3'd6, 8'hFF);
      applyStimulus(0, 0, 8'h00, 0, 3'd0, 8'hFF);

      // Reset while a word waits on a stalled channel 4.
      applyStimulus(0, 1, 8'h55, 1, 3'd4, 8'hEF);
      applyStimulus(0, 0, 8'h00, 1, 3'd4, 8'hEF);
      applyStimulus(1, 0, 8'h00, 1, 3'd4, 8'hEF);
      checkOutput("rst_valid", out_valid8, 0);
      checkOutput("rst_ptr", rr_ptr8, 0);
      applyStimulus(0, 0, 8'h00, 0, 3'd0, 8'hFF);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7),
                       8'($urandom), ($urandom_range(0, 3) == 0),
                       3'($urandom), 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
      $finish;
   end

endmodule
